alu_seq: RTL and testbench

Parametrised, clocked successor to the accumulator ALU; computes on AC/DR operands and drives a carry/extend bit E back to the register file.
Adds start/busy/done handshake, registered zero and error flags, subtraction, and iterative multi-cycle multiply and divide.
Sits between the control unit (issues start and mode) and AC/DR/E writeback; the control unit waits for done before writeback.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq_iter.sv | 81 ++++++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared operation codes and FSM state type for the sequential
// accumulator ALU and its iterative multiply/divide datapath.
package alu_seq_pkg;

  localparam int MODE_W = 4;

  localparam logic [MODE_W-1:0] MODE_ADD   = 4'd0;
  localparam logic [MODE_W-1:0] MODE_ASHL  = 4'd1;
  localparam logic [MODE_W-1:0] MODE_XNOR  = 4'd2;
  localparam logic [MODE_W-1:0] MODE_SHR   = 4'd3;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 4'd4;
  localparam logic [MODE_W-1:0] MODE_STORE = 4'd5;
  localparam logic [MODE_W-1:0] MODE_NEG   = 4'd6;
  localparam logic [MODE_W-1:0] MODE_SUB   = 4'd7;
  localparam logic [MODE_W-1:0] MODE_MUL   = 4'd8;
  localparam logic [MODE_W-1:0] MODE_DIV   = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control unit (master)
// and the ALU (slave). Operands and mode travel with start; the ALU returns
// busy/done and the registered result, extend bit and flags.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic              start;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  ac;
  logic [WIDTH-1:0]  dr;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              e;
  logic              zero;
  logic              err;

  modport master (
    output start, mode, ac, dr,
    input  busy, done, result, e, zero, err
  );

  modport slave (
    input  start, mode, ac, dr,
    output busy, done, result, e, zero, err
  );

endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: one-bit-per-cycle unsigned multiply (shift-add) and
// restoring divide. The hi register holds the upper product half or the
// running remainder; lo holds the multiplier/product-low or the
// dividend/quotient. The *_nxt outputs are the values after the current
// step, so the owner can capture the final answer on the last step.
module alu_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  logic             div_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shl;
  logic [WIDTH:0]   div_diff;

  // Iteration counter: loaded with WIDTH, counts steps down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WIDTH);
    end else if (step && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Operand/partial-result registers; contents are don't-care until a load.
  always_ff @(posedge clk) begin
    if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
    end
  end

  // One shift-add or one restoring-subtract step. The remainder is always
  // below the divisor, so the shifted value fits in WIDTH+1 bits and the
  // difference fits back into WIDTH bits.
  always_comb begin
    addend   = lo_q[0] ? b_q : '0;
    mul_sum  = {1'b0, hi_q} + {1'b0, addend};
    div_shl  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, b_q};
    if (div_q) begin
      if (div_shl >= {1'b0, b_q}) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_shl[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked accumulator ALU. Single-cycle ops complete one cycle
// after start; MUL/DIV run WIDTH steps in alu_seq_iter and report done
// WIDTH+1 cycles after start. Result, extend bit and flags are registered
// and hold between operations.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             finish;
  logic             wr_single;
  logic             wr_div0;
  logic             wr_rsvd;
  logic             last;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH:0]   single_p0;
  logic [WIDTH-1:0] res_p1;
  logic             e_p1;
  logic             zero_p1;
  logic             err_p1;
  logic             vld_p1;

  // Single-cycle ops: returns {e, result}.
  function automatic logic [WIDTH:0] single_op(
    input logic [MODE_W-1:0] m,
    input logic [WIDTH-1:0]  a,
    input logic [WIDTH-1:0]  d
  );
    logic [WIDTH:0] r;
    r = '0;
    case (m)
      MODE_ADD:   r = {1'b0, a} + {1'b0, d};
      MODE_ASHL:  r = {d, 1'b0};
      MODE_XNOR:  r = {1'b0, ~(a ^ d)};
      MODE_SHR:   r = {d[0], 1'b0, d[WIDTH-1:1]};
      MODE_LOAD:  r = {1'b0, d};
      MODE_STORE: r = {1'b0, a};
      MODE_NEG:   r = {(d == '0), (~d + WIDTH'(1))};
      MODE_SUB:   r = {(a >= d), (a - d)};
      default:    r = '0;
    endcase
    return r;
  endfunction

  alu_seq_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (bus.mode == MODE_DIV),
    .a      (bus.ac),
    .b      (bus.dr),
    .last   (last),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  assign single_p0 = single_op(bus.mode, bus.ac, bus.dr);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control: classify the request in IDLE,
  // step the datapath in ITER and finish on the last step.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    wr_single = 1'b0;
    wr_div0   = 1'b0;
    wr_rsvd   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.mode <= MODE_SUB) begin
            wr_single = 1'b1;
          end else if ((bus.mode == MODE_MUL) ||
                       ((bus.mode == MODE_DIV) && (bus.dr != '0))) begin
            load      = 1'b1;
            state_nxt = ITER;
          end else if (bus.mode == MODE_DIV) begin
            wr_div0 = 1'b1;
          end else begin
            wr_rsvd = 1'b1;
          end
        end
      end
      ITER: begin
        step = 1'b1;
        if (last) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output stage: result/flags update with a one-cycle done pulse;
  // reserved modes keep result/e/zero and only raise err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p1  <= '0;
      e_p1    <= 1'b0;
      zero_p1 <= 1'b1;
      err_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (wr_single) begin
        res_p1  <= single_p0[WIDTH-1:0];
        e_p1    <= single_p0[WIDTH];
        zero_p1 <= (single_p0[WIDTH-1:0] == '0);
        err_p1  <= 1'b0;
        vld_p1  <= 1'b1;
      end else if (wr_div0) begin
        res_p1  <= '1;
        e_p1    <= 1'b1;
        zero_p1 <= 1'b0;
        err_p1  <= 1'b1;
        vld_p1  <= 1'b1;
      end else if (wr_rsvd) begin
        err_p1  <= 1'b1;
        vld_p1  <= 1'b1;
      end else if (finish) begin
        res_p1  <= lo_nxt;
        e_p1    <= |hi_nxt;
        zero_p1 <= (lo_nxt == '0);
        err_p1  <= 1'b0;
        vld_p1  <= 1'b1;
      end
    end
  end

  assign bus.busy   = (state == ITER);
  assign bus.done   = vld_p1;
  assign bus.result = res_p1;
  assign bus.e      = e_p1;
  assign bus.zero   = zero_p1;
  assign bus.err    = err_p1;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized bench for alu_seq (WIDTH=8). A
// behavioural model computes each operation with plain arithmetic and
// tracks the remaining iteration cycles; a compare process checks every
// output on every falling edge, and directed cases pin literal values.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  longint unsigned m_result;
  bit              m_e;
  bit              m_zero;
  bit              m_err;
  bit              m_done;
  int              m_cnt;
  longint unsigned p_res;
  bit              p_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void put(input longint unsigned r, input bit ee, input bit er);
    m_result = r & MASK;
    m_e      = ee;
    m_zero   = ((r & MASK) == 0);
    m_err    = er;
    m_done   = 1'b1;
  endfunction

  // Behavioural model, advanced on each rising clock or on reset.
  initial begin
    longint unsigned a, d, s;
    m_result = 0; m_e = 0; m_zero = 1; m_err = 0; m_done = 0; m_cnt = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_result = 0; m_e = 0; m_zero = 1; m_err = 0; m_done = 0; m_cnt = 0;
      end else begin
        a = longint'(bus.ac);
        d = longint'(bus.dr);
        m_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) put(p_res, p_e, 1'b0);
        end else if (bus.start) begin
          case (int'(bus.mode))
            0: begin s = a + d; put(s, (s >> W) != 0, 1'b0); end
            1: put(d << 1, ((d >> (W - 1)) & 1) != 0, 1'b0);
            2: put(~(a ^ d), 1'b0, 1'b0);
            3: put(d >> 1, (d & 1) != 0, 1'b0);
            4: put(d, 1'b0, 1'b0);
            5: put(a, 1'b0, 1'b0);
            6: put((MASK + 1) - d, d == 0, 1'b0);
            7: put(a - d, a >= d, 1'b0);
            8: begin
              s = a * d;
              p_res = s & MASK;
              p_e = (s >> W) != 0;
              m_cnt = W;
            end
            9: begin
              if (d == 0) put(MASK, 1'b1, 1'b1);
              else begin
                p_res = a / d;
                p_e = (a % d) != 0;
                m_cnt = W;
              end
            end
            default: begin m_err = 1'b1; m_done = 1'b1; end
          endcase
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy",   bus.busy,   m_cnt > 0);
        check("done",   bus.done,   m_done);
        check("result", bus.result, m_result);
        check("e",      bus.e,      m_e);
        check("zero",   bus.zero,   m_zero);
        check("err",    bus.err,    m_err);
      end
    end
  end

  task automatic issue(input logic [3:0] m, input logic [W-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.ac = a; bus.dr = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called on the falling edge where cycle number 'lat0' after start is visible.
  task automatic wait_done(input string name, input int lat0, input int exp_lat);
    int lat;
    lat = lat0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int done_seen;
    logic [3:0] m;
    bus.start = 1'b0; bus.mode = '0; bus.ac = '0; bus.dr = '0;
    repeat (2) @(negedge clk);

    check("rst_result", bus.result, 0);
    check("rst_e",      bus.e,      0);
    check("rst_zero",   bus.zero,   1);
    check("rst_err",    bus.err,    0);
    check("rst_done",   bus.done,   0);
    check("rst_busy",   bus.busy,   0);
    rst = 1'b0;
    chk_en = 1'b1;

    issue(MODE_ADD, 8'hFF, 8'h01);
    wait_done("add", 1, 1);
    check("add_result", bus.result, 8'h00);
    check("add_e",      bus.e,      1);
    check("add_zero",   bus.zero,   1);
    check("add_err",    bus.err,    0);

    issue(MODE_SUB, 8'h05, 8'h07);
    wait_done("sub", 1, 1);
    check("sub_result", bus.result, 8'hFE);
    check("sub_e",      bus.e,      0);

    issue(MODE_NEG, 8'h00, 8'h05);
    wait_done("neg", 1, 1);
    check("neg_result", bus.result, 8'hFB);
    check("neg_e",      bus.e,      0);

    @(negedge clk);
    bus.start = 1'b1; bus.mode = MODE_ADD; bus.ac = 8'h01; bus.dr = 8'h02;
    @(negedge clk);
    check("b2b_done1",   bus.done,   1);
    check("b2b_result1", bus.result, 8'h03);
    bus.mode = MODE_SUB; bus.ac = 8'h09; bus.dr = 8'h04;
    @(negedge clk);
    check("b2b_done2",   bus.done,   1);
    check("b2b_result2", bus.result, 8'h05);
    bus.mode = MODE_LOAD; bus.dr = 8'h42;
    @(negedge clk);
    check("b2b_done3",   bus.done,   1);
    check("b2b_result3", bus.result, 8'h42);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_done_off", bus.done, 0);

    issue(MODE_MUL, 8'h10, 8'h20);
    check("mul_busy", bus.busy, 1);
    wait_done("mul1", 1, 9);
    check("mul1_busy",   bus.busy,   0);
    check("mul1_result", bus.result, 8'h00);
    check("mul1_e",      bus.e,      1);
    check("mul1_zero",   bus.zero,   1);

    issue(MODE_MUL, 8'h0C, 8'h0B);
    wait_done("mul2", 1, 9);
    check("mul2_result", bus.result, 8'h84);
    check("mul2_e",      bus.e,      0);

    issue(MODE_DIV, 8'd200, 8'd7);
    wait_done("div", 1, 9);
    check("div_result", bus.result, 8'd28);
    check("div_e",      bus.e,      1);
    check("div_err",    bus.err,    0);

    issue(MODE_DIV, 8'd8, 8'd0);
    wait_done("div0", 1, 1);
    check("div0_result", bus.result, 8'hFF);
    check("div0_e",      bus.e,      1);
    check("div0_err",    bus.err,    1);

    issue(MODE_MUL, 8'h0C, 8'h0B);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.mode = MODE_ADD; bus.ac = 8'hFF; bus.dr = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("mul_ign", 4, 9);
    check("mul_ign_result", bus.result, 8'h84);
    check("mul_ign_e",      bus.e,      0);

    issue(MODE_MUL, 8'h10, 8'h20);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("amid_result", bus.result, 0);
    check("amid_e",      bus.e,      0);
    check("amid_zero",   bus.zero,   1);
    check("amid_err",    bus.err,    0);
    check("amid_done",   bus.done,   0);
    check("amid_busy",   bus.busy,   0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("amid_no_done", done_seen, 0);

    issue(MODE_LOAD, 8'h00, 8'h42);
    wait_done("load42", 1, 1);
    issue(4'hA, 8'h13, 8'h57);
    wait_done("rsvd", 1, 1);
    check("rsvd_result", bus.result, 8'h42);
    check("rsvd_err",    bus.err,    1);
    issue(MODE_ADD, 8'h01, 8'h01);
    wait_done("add_clr", 1, 1);
    check("clr_err",    bus.err,    0);
    check("clr_result", bus.result, 8'h02);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) m = 4'(8 + $urandom_range(0, 1));
      bus.start = ($urandom_range(0, 3) != 0);
      bus.mode  = m;
      bus.ac    = W'($urandom);
      bus.dr    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

endmodule
